// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin arbiter that shares the single write port of
// register_file among NumReq requesters and sequences a full-array clear.
// Optional build macro: REGFILE_ARB_CLEAR_ON_RESET_EN (reset enters CLEAR instead of IDLE).
module regfile_write_arbiter #(
  parameter int unsigned          NumReq    = 3,
  parameter int unsigned          DataSize  = 32,
  parameter int unsigned          DataWidth = 32,
  parameter logic [DataWidth-1:0] ClearVal  = '0
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          clear_i,
  output logic                          busy_o,
  input  logic [NumReq-1:0]             req_i,
  input  logic [NumReq*$clog2(DataSize)-1:0] addr_i,
  input  logic [NumReq*DataWidth-1:0]   wdata_i,
  output logic [NumReq-1:0]             gnt_o,
  output logic [$clog2(DataSize)-1:0]   waddr_o,
  output logic [DataWidth-1:0]          wdata_o,
  output logic                          we_o
);

  localparam int unsigned AddrWidth = $clog2(DataSize);
  localparam int unsigned NumWords  = 2 ** AddrWidth;
  localparam int unsigned PtrW      = (NumReq > 1) ? $clog2(NumReq) : 1;

  typedef enum logic [0:0] {IDLE, CLEAR} state_e;

`ifdef REGFILE_ARB_CLEAR_ON_RESET_EN
  localparam state_e RstState = CLEAR;
`else
  localparam state_e RstState = IDLE;
`endif

  state_e                 state_q;
  logic [AddrWidth-1:0]   cnt_q;
  logic [PtrW-1:0]        ptr_q;

  logic [NumReq-1:0]      gnt;
  logic                   gnt_any;
  logic [PtrW-1:0]        gnt_idx;
  logic [PtrW-1:0]        ptr_next;

  logic [AddrWidth-1:0]   addr_arr  [NumReq];
  logic [DataWidth-1:0]   wdata_arr [NumReq];

  // Unpack the per-requester address/data slices.
  for (genvar g = 0; g < NumReq; g++) begin : g_unpack
    assign addr_arr[g]  = addr_i[g*AddrWidth +: AddrWidth];
    assign wdata_arr[g] = wdata_i[g*DataWidth +: DataWidth];
  end

  // Round-robin search from ptr upward with wrap; clear and reset suppress grants.
  always_comb begin
    int unsigned sum;
    logic [PtrW-1:0] idx;
    sum     = 0;
    idx     = '0;
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    if (rst_ni && (state_q == IDLE) && !clear_i) begin
      for (int unsigned i = 0; i < NumReq; i++) begin
        sum = 32'(ptr_q) + i;
        if (sum >= NumReq) sum = sum - NumReq;
        idx = PtrW'(sum);
        if (!gnt_any && req_i[idx]) begin
          gnt_any  = 1'b1;
          gnt_idx  = idx;
          gnt[idx] = 1'b1;
        end
      end
    end
  end

  // Pointer moves just past the winner, wrapping to zero after the last requester.
  always_comb begin
    ptr_next = '0;
    if (gnt_idx != PtrW'(NumReq - 1)) ptr_next = gnt_idx + PtrW'(1);
  end

  assign gnt_o  = gnt;
  assign busy_o = (state_q == CLEAR);

  // FSM, pointer, clear counter and registered write-port outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RstState;
      cnt_q   <= '0;
      ptr_q   <= '0;
      we_o    <= 1'b0;
      waddr_o <= '0;
      wdata_o <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clear_i) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            we_o    <= 1'b0;
          end else if (gnt_any) begin
            ptr_q   <= ptr_next;
            we_o    <= 1'b1;
            waddr_o <= addr_arr[gnt_idx];
            wdata_o <= wdata_arr[gnt_idx];
          end else begin
            we_o <= 1'b0;
          end
        end
        CLEAR: begin
          we_o    <= 1'b1;
          waddr_o <= cnt_q;
          wdata_o <= ClearVal;
          cnt_q   <= cnt_q + AddrWidth'(1);
          if (cnt_q == AddrWidth'(NumWords - 1)) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a behavioral register-file model.
module tb_regfile_write_arbiter;

  localparam int unsigned NumReq = 3;
  localparam int unsigned AW     = 5;
  localparam int unsigned DW     = 32;

  logic                 clk;
  logic                 rst_n;
  logic                 clear;
  logic                 busy;
  logic [NumReq-1:0]    req;
  logic [NumReq*AW-1:0] addr;
  logic [NumReq*DW-1:0] wdata;
  logic [NumReq-1:0]    gnt;
  logic [AW-1:0]        waddr;
  logic [DW-1:0]        wdo;
  logic                 we;

  logic [DW-1:0] mem [32];

  int n_tests = 0;
  int n_fail  = 0;

  regfile_write_arbiter #(
    .NumReq(NumReq), .DataSize(32), .DataWidth(DW), .ClearVal('0)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .busy_o(busy),
    .req_i(req), .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt),
    .waddr_o(waddr), .wdata_o(wdo), .we_o(we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream register file: written at the end of the cycle we_o is high.
  always @(posedge clk) if (we) mem[waddr] <= wdo;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [2:0]  rr_gnt [6];
  logic [AW-1:0] rr_addr [3];
  int bad;

  initial begin
    rr_gnt[0] = 3'b001; rr_gnt[1] = 3'b010; rr_gnt[2] = 3'b100;
    rr_gnt[3] = 3'b001; rr_gnt[4] = 3'b010; rr_gnt[5] = 3'b100;
    rr_addr[0] = 5'd3; rr_addr[1] = 5'd12; rr_addr[2] = 5'd29;

    rst_n = 1'b0; clear = 1'b0; req = 3'b111;
    for (int i = 0; i < NumReq; i++) begin
      addr[i*AW +: AW]  = rr_addr[i];
      wdata[i*DW +: DW] = 32'h1000_0000 + 32'(i);
    end

    // Reset values, with all requests already high.
    repeat (2) @(negedge clk);
    #1;
    check("rst_we", 64'(we), 64'd0);
    check("rst_waddr", 64'(waddr), 64'd0);
    check("rst_wdata", 64'(wdo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_gnt", 64'(gnt), 64'd0);

    // Round robin with all three requesting from reset.
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      check($sformatf("rr_gnt%0d", k), 64'(gnt), 64'(rr_gnt[k]));
      if (k > 0) begin
        check($sformatf("rr_we%0d", k), 64'(we), 64'd1);
        check($sformatf("rr_waddr%0d", k), 64'(waddr), 64'(rr_addr[(k-1)%3]));
        check($sformatf("rr_wdata%0d", k), 64'(wdo), 64'(32'h1000_0000 + 32'((k-1)%3)));
      end
      @(negedge clk);
    end
    req = 3'b000;
    #1;
    check("rr_we_last", 64'(we), 64'd1);
    check("rr_waddr_last", 64'(waddr), 64'(rr_addr[2]));
    check("rr_gnt_none", 64'(gnt), 64'd0);
    @(negedge clk);
    #1;
    check("idle_we", 64'(we), 64'd0);
    check("idle_waddr_hold", 64'(waddr), 64'(rr_addr[2]));

    // Single requester 1 writing DEADBEEF to address 5.
    req = 3'b010;
    addr[1*AW +: AW]  = 5'd5;
    wdata[1*DW +: DW] = 32'hDEAD_BEEF;
    #1;
    check("single_gnt", 64'(gnt), 64'b010);
    @(negedge clk);
    req = 3'b000;
    #1;
    check("single_we", 64'(we), 64'd1);
    check("single_waddr", 64'(waddr), 64'd5);
    check("single_wdata", 64'(wdo), 64'hDEAD_BEEF);
    @(negedge clk);
    #1;
    check("single_mem5", 64'(mem[5]), 64'hDEAD_BEEF);
    check("single_we_off", 64'(we), 64'd0);

    // Fairness: ptr is 2 here; a grant to requester 0 moves it to 1.
    req = 3'b001;
    #1;
    check("fair_gnt_a", 64'(gnt), 64'b001);
    @(negedge clk);
    #1;
    check("fair_gnt_b", 64'(gnt), 64'b001);
    @(negedge clk);
    req = 3'b101;
    #1;
    check("fair_gnt_skip", 64'(gnt), 64'b100);
    @(negedge clk);
    req = 3'b000;

    // Clear with requester 0 held, plus a second clear pulse while busy.
    addr[0*AW +: AW]  = 5'd7;
    wdata[0*DW +: DW] = 32'hA5A5_0000;
    clear = 1'b1;
    req   = 3'b001;
    #1;
    check("clr_gnt_t0", 64'(gnt), 64'd0);
    check("clr_busy_t0", 64'(busy), 64'd0);
    for (int j = 1; j <= 33; j++) begin
      @(negedge clk);
      clear = (j == 5);
      #1;
      if (j <= 32) begin
        check($sformatf("clr_busy%0d", j), 64'(busy), 64'd1);
        check($sformatf("clr_gnt%0d", j), 64'(gnt), 64'd0);
      end else begin
        check("clr_busy_end", 64'(busy), 64'd0);
        check("clr_gnt_after", 64'(gnt), 64'b001);
      end
      if (j == 1) check("clr_we_first", 64'(we), 64'd0);
      else begin
        check($sformatf("clr_we%0d", j), 64'(we), 64'd1);
        check($sformatf("clr_waddr%0d", j), 64'(waddr), 64'(j - 2));
        check($sformatf("clr_wdata%0d", j), 64'(wdo), 64'd0);
      end
    end
    @(negedge clk);
    req = 3'b000;
    #1;
    check("post_clr_we", 64'(we), 64'd1);
    check("post_clr_waddr", 64'(waddr), 64'd7);
    check("post_clr_wdata", 64'(wdo), 64'hA5A5_0000);
    check("post_clr_busy", 64'(busy), 64'd0);
    @(negedge clk);
    #1;
    bad = 0;
    for (int w = 0; w < 32; w++) begin
      if (mem[w] !== ((w == 7) ? 32'hA5A5_0000 : 32'h0)) bad++;
    end
    check("post_clr_mem_bad_words", 64'(bad), 64'd0);

    // Reset asserted mid-clear while cnt is 10.
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    check("mid_busy", 64'(busy), 64'd1);
    check("mid_waddr", 64'(waddr), 64'd9);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_we", 64'(we), 64'd0);
    check("arst_waddr", 64'(waddr), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_gnt", 64'(gnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req   = 3'b010;
    #1;
    check("rel_busy", 64'(busy), 64'd0);
    check("rel_gnt", 64'(gnt), 64'b010);
    @(negedge clk);
    req = 3'b000;
    #1;
    check("rel_we", 64'(we), 64'd1);
    check("rel_waddr", 64'(waddr), 64'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
